// File: rtl/lcd_pattern_gen_pkg.sv
// Shared definitions for the LCD test-pattern source: pattern modes,
// colours, bounce axis state and raster-total derivation.
package lcd_pattern_gen_pkg;

  localparam logic [1:0] PAT_WHITE  = 2'd0;
  localparam logic [1:0] PAT_STATIC = 2'd1;
  localparam logic [1:0] PAT_BOUNCE = 2'd2;
  localparam logic [1:0] PAT_BARS   = 2'd3;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  // Position and travel direction of the square along one axis.
  typedef struct packed {
    logic [11:0] pos;
    logic        dir;
  } axis_state_t;

  function automatic int unsigned calc_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] col;
    case (idx)
      3'd0:    col = COL_WHITE;
      3'd1:    col = COL_YELLOW;
      3'd2:    col = COL_CYAN;
      3'd3:    col = COL_GREEN;
      3'd4:    col = COL_MAGENTA;
      3'd5:    col = COL_RED;
      3'd6:    col = COL_BLUE;
      default: col = COL_BLACK;
    endcase
    return col;
  endfunction

  // One frame of bounce: move by step; on overshoot reverse and clamp.
  function automatic axis_state_t bounce_step(input axis_state_t cur,
                                              input int unsigned step,
                                              input int unsigned limit);
    axis_state_t nxt;
    int          cand;
    nxt  = cur;
    cand = (cur.dir == DIR_POS) ? int'(cur.pos) + int'(step)
                                : int'(cur.pos) - int'(step);
    if (cand < 0 || cand > int'(limit)) begin
      nxt.dir = ~cur.dir;
      cand = (cur.dir == DIR_POS) ? int'(cur.pos) - int'(step)
                                  : int'(cur.pos) + int'(step);
      if (cand < 0) begin
        cand = 0;
      end else if (cand > int'(limit)) begin
        cand = int'(limit);
      end
    end
    nxt.pos = 12'(cand);
    return nxt;
  endfunction

endpackage

// File: rtl/lcd_pattern_gen_timing_core.sv
// Raster timing: pixel/line counters, registered sync/enable/coordinate
// outputs and the end-of-frame commit strobe.
module lcd_timing_core
  import lcd_pattern_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] h_cnt,
  output logic [11:0] v_cnt,
  output logic        active,
  output logic        commit,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [11:0] lcd_xpos,
  output logic [11:0] lcd_ypos,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic hs_pulse;
  logic vs_pulse;

  // Decode raster position into region flags.
  always_comb begin
    active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    commit   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    hs_pulse = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    vs_pulse = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  end

  // Pixel and line counters, line advances on pixel wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Registered stream outputs, one cycle behind the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_hs      <= 1'b1;
      lcd_vs      <= 1'b1;
      lcd_de      <= 1'b0;
      lcd_xpos    <= '0;
      lcd_ypos    <= '0;
      frame_start <= 1'b0;
    end else begin
      lcd_hs      <= ~hs_pulse;
      lcd_vs      <= ~vs_pulse;
      lcd_de      <= active;
      lcd_xpos    <= active ? h_cnt : '0;
      lcd_ypos    <= active ? v_cnt : '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: rtl/lcd_pattern_gen.sv
// Test-pattern source: per-frame mode shadowing, square position
// (static or bouncing) and registered RGB888 pixel generation.
module lcd_pattern_gen
  import lcd_pattern_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter int unsigned OBJ_SIZE = 64,
  parameter int unsigned STEP     = 2
) (
  input  logic        hdmi_clk1x_i,
  input  logic        rst_i,
  input  logic [1:0]  pattern_mode_i,
  input  logic [11:0] cfg_x_i,
  input  logic [11:0] cfg_y_i,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [23:0] lcd_data,
  output logic [11:0] lcd_xpos,
  output logic [11:0] lcd_ypos,
  output logic        frame_start,
  output logic [11:0] obj_x_o,
  output logic [11:0] obj_y_o
);

  localparam int unsigned X_LIMIT_I = H_ACTIVE - OBJ_SIZE;
  localparam int unsigned Y_LIMIT_I = V_ACTIVE - OBJ_SIZE;
  localparam logic [11:0] X_LIMIT   = 12'(X_LIMIT_I);
  localparam logic [11:0] Y_LIMIT   = 12'(Y_LIMIT_I);
  localparam int unsigned BAR_W     = H_ACTIVE / 8;

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        active;
  logic        commit;

  logic [1:0]  mode_q;
  axis_state_t x_st;
  axis_state_t y_st;
  axis_state_t x_bounce;
  axis_state_t y_bounce;
  logic [11:0] x_static;
  logic [11:0] y_static;

  logic [12:0] x_end;
  logic [12:0] y_end;
  logic        in_square;
  logic [2:0]  bar_idx;
  logic [23:0] pixel;

  lcd_timing_core #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (hdmi_clk1x_i),
    .rst         (rst_i),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (active),
    .commit      (commit),
    .lcd_hs      (lcd_hs),
    .lcd_vs      (lcd_vs),
    .lcd_de      (lcd_de),
    .lcd_xpos    (lcd_xpos),
    .lcd_ypos    (lcd_ypos),
    .frame_start (frame_start)
  );

  // Candidate square positions for the next frame.
  always_comb begin
    x_bounce = bounce_step(x_st, STEP, X_LIMIT_I);
    y_bounce = bounce_step(y_st, STEP, Y_LIMIT_I);
    x_static = (cfg_x_i > X_LIMIT) ? X_LIMIT : cfg_x_i;
    y_static = (cfg_y_i > Y_LIMIT) ? Y_LIMIT : cfg_y_i;
  end

  // Frame commit: shadow the mode and move the square once per frame.
  always_ff @(posedge hdmi_clk1x_i) begin
    if (rst_i) begin
      mode_q <= PAT_WHITE;
      x_st   <= '{pos: '0, dir: DIR_POS};
      y_st   <= '{pos: '0, dir: DIR_POS};
    end else if (commit) begin
      mode_q <= pattern_mode_i;
      case (pattern_mode_i)
        PAT_STATIC: begin
          x_st.pos <= x_static;
          y_st.pos <= y_static;
        end
        PAT_BOUNCE: begin
          x_st <= x_bounce;
          y_st <= y_bounce;
        end
        default: begin
          x_st <= x_st;
          y_st <= y_st;
        end
      endcase
    end
  end

  assign obj_x_o = x_st.pos;
  assign obj_y_o = y_st.pos;

  // Pixel colour for the current counter position.
  always_comb begin
    x_end     = {1'b0, x_st.pos} + 13'(OBJ_SIZE - 1);
    y_end     = {1'b0, y_st.pos} + 13'(OBJ_SIZE - 1);
    in_square = (h_cnt >= x_st.pos) && ({1'b0, h_cnt} <= x_end) &&
                (v_cnt >= y_st.pos) && ({1'b0, v_cnt} <= y_end);
    // Last bar absorbs the remainder of H_ACTIVE/8.
    bar_idx = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (h_cnt >= 12'(i * BAR_W)) begin
        bar_idx = 3'(i);
      end
    end
    case (mode_q)
      PAT_STATIC, PAT_BOUNCE: pixel = in_square ? COL_BLACK : COL_WHITE;
      PAT_BARS:               pixel = bar_colour(bar_idx);
      default:                pixel = COL_WHITE;
    endcase
  end

  // Registered pixel, aligned with the timing core outputs.
  always_ff @(posedge hdmi_clk1x_i) begin
    if (rst_i) begin
      lcd_data <= '0;
    end else begin
      lcd_data <= active ? pixel : '0;
    end
  end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Self-checking bench for lcd_pattern_gen on a small raster.
module tb_lcd_pattern_gen;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 8,  VFP = 1, VSW = 2, VBP = 1;
  localparam int OBJ = 4, STEP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int TOT = HT * VT;
  localparam int XLIM = HA - OBJ;
  localparam int YLIM = VA - OBJ;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [11:0] cfg_x, cfg_y;
  logic        lcd_hs, lcd_vs, lcd_de, frame_start;
  logic [23:0] lcd_data;
  logic [11:0] lcd_xpos, lcd_ypos, obj_x_o, obj_y_o;

  always #5 clk = ~clk;

  lcd_pattern_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .OBJ_SIZE (OBJ), .STEP (STEP)
  ) dut (
    .hdmi_clk1x_i   (clk),
    .rst_i          (rst),
    .pattern_mode_i (mode),
    .cfg_x_i        (cfg_x),
    .cfg_y_i        (cfg_y),
    .lcd_hs         (lcd_hs),
    .lcd_vs         (lcd_vs),
    .lcd_de         (lcd_de),
    .lcd_data       (lcd_data),
    .lcd_xpos       (lcd_xpos),
    .lcd_ypos       (lcd_ypos),
    .frame_start    (frame_start),
    .obj_x_o        (obj_x_o),
    .obj_y_o        (obj_y_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: linear position in the frame plus per-frame state.
  int cnt = 0;
  int m_mode = 0, m_ox = 0, m_oy = 0, m_dx = 1, m_dy = 1;

  // Statistics over a window of ticks.
  int tick_no = 0, last_fs = -1;
  int st_de, st_fs, st_fs_gap_bad, st_hs_low, st_vs_low;
  int st_black, st_black_left, st_sumx, st_sumy, st_nonwhite;

  function automatic logic [23:0] model_pixel(int x, int y);
    int idx;
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    if (m_mode == 1 || m_mode == 2) begin
      if (x >= m_ox && x < m_ox + OBJ && y >= m_oy && y < m_oy + OBJ)
        return 24'h000000;
      return 24'hFFFFFF;
    end
    if (m_mode == 3) begin
      idx = x / (HA / 8);
      if (idx > 7) idx = 7;
      return bars[idx];
    end
    return 24'hFFFFFF;
  endfunction

  task automatic bounce(inout int p, inout int d, input int lim);
    int c;
    c = p + d * STEP;
    if (c < 0 || c > lim) begin
      d = -d;
      c = p + d * STEP;
      if (c < 0) c = 0;
      if (c > lim) c = lim;
    end
    p = c;
  endtask

  task automatic clear_stats();
    st_de = 0; st_fs = 0; st_fs_gap_bad = 0; st_hs_low = 0; st_vs_low = 0;
    st_black = 0; st_black_left = 0; st_sumx = 0; st_sumy = 0; st_nonwhite = 0;
    last_fs = -1;
  endtask

  // One clock: predict, advance, then compare every output.
  task automatic tick();
    int h, v;
    bit act, do_commit;
    logic e_hs, e_vs, e_de, e_fs;
    logic [11:0] e_x, e_y, e_ox, e_oy;
    logic [23:0] e_d;
    h = cnt % HT;
    v = cnt / HT;
    act = (h < HA) && (v < VA);
    if (rst) begin
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0;
      e_x = '0; e_y = '0; e_d = '0;
    end else begin
      e_hs = !(h >= HA + HFP && h < HA + HFP + HSW);
      e_vs = !(v >= VA + VFP && v < VA + VFP + VSW);
      e_de = act;
      e_fs = (cnt == 0);
      e_x  = act ? 12'(h) : 12'd0;
      e_y  = act ? 12'(v) : 12'd0;
      e_d  = act ? model_pixel(h, v) : 24'd0;
    end
    do_commit = !rst && (cnt == TOT - 1);
    if (do_commit) begin
      m_mode = int'(mode);
      if (mode == 2'd1) begin
        m_ox = (int'(cfg_x) > XLIM) ? XLIM : int'(cfg_x);
        m_oy = (int'(cfg_y) > YLIM) ? YLIM : int'(cfg_y);
      end else if (mode == 2'd2) begin
        bounce(m_ox, m_dx, XLIM);
        bounce(m_oy, m_dy, YLIM);
      end
    end
    if (rst) begin
      cnt = 0; m_mode = 0; m_ox = 0; m_oy = 0; m_dx = 1; m_dy = 1;
    end else begin
      cnt = (cnt + 1) % TOT;
    end
    e_ox = 12'(m_ox);
    e_oy = 12'(m_oy);
    @(posedge clk);
    #1;
    tick_no++;
    n_cmp++;
    if ({lcd_hs, lcd_vs, lcd_de, lcd_xpos, lcd_ypos, frame_start} !==
        {e_hs, e_vs, e_de, e_x, e_y, e_fs}) begin
      n_err++;
      $display("FAIL timing tick=%0d: got hs=%b vs=%b de=%b x=%0d y=%0d fs=%b, expected hs=%b vs=%b de=%b x=%0d y=%0d fs=%b",
               tick_no, lcd_hs, lcd_vs, lcd_de, lcd_xpos, lcd_ypos, frame_start,
               e_hs, e_vs, e_de, e_x, e_y, e_fs);
    end
    n_cmp++;
    if (lcd_data !== e_d) begin
      n_err++;
      $display("FAIL data tick=%0d (h=%0d v=%0d): got %06h, expected %06h",
               tick_no, h, v, lcd_data, e_d);
    end
    n_cmp++;
    if ({obj_x_o, obj_y_o} !== {e_ox, e_oy}) begin
      n_err++;
      $display("FAIL obj tick=%0d: got (%0d,%0d), expected (%0d,%0d)",
               tick_no, obj_x_o, obj_y_o, e_ox, e_oy);
    end
    if (lcd_de === 1'b1) st_de++;
    if (frame_start === 1'b1) begin
      st_fs++;
      if (last_fs >= 0 && tick_no - last_fs != TOT) st_fs_gap_bad++;
      last_fs = tick_no;
    end
    if (lcd_hs === 1'b0) st_hs_low++;
    if (lcd_vs === 1'b0) st_vs_low++;
    if (lcd_de === 1'b1 && lcd_data === 24'h0) begin
      st_black++;
      st_sumx += int'(lcd_xpos);
      st_sumy += int'(lcd_ypos);
      if (lcd_xpos < 12'd14) st_black_left++;
    end
    if (lcd_de === 1'b1 && lcd_data !== 24'hFFFFFF) st_nonwhite++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance through one commit to the first pixel of the following frame.
  task automatic next_frame();
    tick();
    for (int i = 0; i < TOT && cnt != 0; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run(2);
    n_cmp++;
    if ({lcd_hs, lcd_vs, lcd_de, lcd_data, frame_start} !== {1'b1, 1'b1, 1'b0, 24'h0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got hs=%b vs=%b de=%b data=%06h fs=%b, expected 1 1 0 000000 0",
               lcd_hs, lcd_vs, lcd_de, lcd_data, frame_start);
    end
    rst = 1'b0;
  endtask

  task automatic test_timing();
    clear_stats();
    run(2 * TOT);
    n_cmp++;
    if (st_de != 2 * HA * VA) begin n_err++; $display("FAIL de_count: got %0d, expected %0d", st_de, 2 * HA * VA); end
    n_cmp++;
    if (st_fs != 2) begin n_err++; $display("FAIL frame_start_count: got %0d, expected 2", st_fs); end
    n_cmp++;
    if (st_fs_gap_bad != 0) begin n_err++; $display("FAIL frame_period: got %0d bad gaps, expected 0", st_fs_gap_bad); end
    n_cmp++;
    if (st_hs_low != 2 * VT * HSW) begin n_err++; $display("FAIL hs_low: got %0d, expected %0d", st_hs_low, 2 * VT * HSW); end
    n_cmp++;
    if (st_vs_low != 2 * VSW * HT) begin n_err++; $display("FAIL vs_low: got %0d, expected %0d", st_vs_low, 2 * VSW * HT); end
  endtask

  task automatic test_static();
    mode = 2'd1; cfg_x = 12'd5; cfg_y = 12'd2;
    next_frame();
    clear_stats();
    run(TOT);
    n_cmp++;
    if (st_black != 16) begin n_err++; $display("FAIL static_black: got %0d, expected 16", st_black); end
    n_cmp++;
    if (st_black == 0 || st_sumx / st_black != 6 || st_sumy / st_black != 3) begin
      n_err++;
      $display("FAIL static_centroid: got sums (%0d,%0d) over %0d, expected average (6,3)", st_sumx, st_sumy, st_black);
    end
  endtask

  task automatic test_clamp();
    mode = 2'd1; cfg_x = 12'd30; cfg_y = 12'd30;
    next_frame();
    n_cmp++;
    if (obj_x_o !== 12'd12 || obj_y_o !== 12'd4) begin
      n_err++;
      $display("FAIL clamp_obj: got (%0d,%0d), expected (12,4)", obj_x_o, obj_y_o);
    end
    clear_stats();
    run(TOT);
    n_cmp++;
    if (st_black != 16 || st_sumx != 216) begin
      n_err++;
      $display("FAIL clamp_pixels: got black=%0d sumx=%0d, expected 16 and 216", st_black, st_sumx);
    end
  endtask

  task automatic test_bounce();
    int ex [7];
    int ey [7];
    ex = '{2, 4, 6, 8, 10, 12, 10};
    ey = '{2, 4, 2, 0, 2, 4, 2};
    mode = 2'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mode = 2'd2;
    for (int k = 0; k < 7; k++) begin
      next_frame();
      n_cmp++;
      if (int'(obj_x_o) != ex[k] || int'(obj_y_o) != ey[k]) begin
        n_err++;
        $display("FAIL bounce_step%0d: got (%0d,%0d), expected (%0d,%0d)", k, obj_x_o, obj_y_o, ex[k], ey[k]);
      end
    end
  endtask

  task automatic test_midframe();
    mode = 2'd3;
    next_frame();
    run(4 * HT);
    mode = 2'd1; cfg_x = 12'd5; cfg_y = 12'd2;
    clear_stats();
    run(TOT - 4 * HT);
    n_cmp++;
    if (st_black != 8 || st_black_left != 0) begin
      n_err++;
      $display("FAIL midframe_bars: got black=%0d left=%0d, expected 8 and 0", st_black, st_black_left);
    end
    clear_stats();
    run(TOT);
    n_cmp++;
    if (st_black != 16 || st_sumx != 104) begin
      n_err++;
      $display("FAIL midframe_square: got black=%0d sumx=%0d, expected 16 and 104", st_black, st_sumx);
    end
  endtask

  task automatic test_reset_midline();
    mode = 2'd3;
    next_frame();
    run(3 * HT + 7);
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({lcd_hs, lcd_vs, lcd_de, lcd_data} !== {1'b1, 1'b1, 1'b0, 24'h0}) begin
      n_err++;
      $display("FAIL midline_reset: got hs=%b vs=%b de=%b data=%06h, expected 1 1 0 000000",
               lcd_hs, lcd_vs, lcd_de, lcd_data);
    end
    rst = 1'b0;
    clear_stats();
    run(TOT);
    n_cmp++;
    if (st_nonwhite != 0 || st_de != HA * VA || st_fs != 1) begin
      n_err++;
      $display("FAIL post_reset_frame: got nonwhite=%0d de=%0d fs=%0d, expected 0 %0d 1",
               st_nonwhite, st_de, st_fs, HA * VA);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 10; f++) begin
      mode  = 2'($urandom_range(0, 3));
      cfg_x = 12'($urandom_range(0, 20));
      cfg_y = 12'($urandom_range(0, 12));
      run($urandom_range(1, TOT));
    end
    mode = 2'd2;
    run(6 * TOT);
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; cfg_x = '0; cfg_y = '0;
    clear_stats();
    test_reset();
    test_timing();
    test_static();
    test_clamp();
    test_bounce();
    test_midframe();
    test_reset_midline();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
